// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Instruction memory with a valid/ready fetch port and a fixed, parameterised
// response latency. It sits between the PC/fetch stage and the instruction
// register.
//
// Handshake semantics (both channels):
// - A transfer happens on a rising edge where valid and ready are both 1.
// - Once a requester raises valid, it holds valid and its payload stable
//   until that transfer edge.
// - The response side holds rsp_valid, rsp_instr and rsp_err stable until
//   rsp_ready is seen.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   fetch request handshake
//   req_addr   [ADDR_W]   byte address of the fetch
//   rsp_valid/rsp_ready   response handshake
//   rsp_instr  [DATA_W]   fetched word; 0 when rsp_err is set
//   rsp_err               misaligned or out-of-range fetch
//   prog_we/prog_addr/prog_data
//                         program-load write port, independent of the fetch
//                         handshake and active even during reset
//   fetch_cnt  [16]       completed responses (normal and error), wrapping
//
// Only one request is in flight at a time. The memory is not cleared by reset.
module imem_fetch_ctrl #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 512,
  parameter int                LATENCY   = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_instr,
  output logic                     rsp_err,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
  output logic [15:0]              fetch_cnt
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  word_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              fetch_err;
  logic              accept;
  logic              rsp_fire;

  // Address decode. The subtraction wraps, so addresses below BASE_ADDR turn
  // into huge offsets and fall out of range naturally.
  assign offset       = req_addr - BASE_ADDR;
  assign word_idx     = offset[IDX_W+1:2];
  assign misaligned   = (req_addr[1:0] != 2'b00);
  assign out_of_range = ((offset >> (IDX_W + 2)) != '0);
  assign fetch_err    = misaligned | out_of_range;

  assign accept   = req_valid & req_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

  // Program port: no reset dependency, so code loaded before or during reset
  // survives it.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // State register and response datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rsp_instr <= '0;
      rsp_err   <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // The read happens at the accept edge. A prog_we to the same word on
      // that edge lands after the read, so the old word is returned.
      if (accept) begin
        rsp_err   <= fetch_err;
        rsp_instr <= fetch_err ? '0 : mem[word_idx];
      end
      if (rsp_fire) begin
        fetch_cnt <= fetch_cnt + 16'd1;
      end
    end
  end

  // Next-state logic. The WAIT counter is loaded with LATENCY-1 and leaves at
  // 1, so rsp_valid is first sampled high LATENCY edges after the accept edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs. req_ready is gated by rst_n so it stays low for the whole
  // reset, even though the state register is already IDLE after the first
  // reset edge.
  always_comb begin
    req_ready = rst_n && (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  // ---------------- clock / reset / signals ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic [31:0] req_addr  [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_instr [3];
  logic        rsp_err   [3];
  logic        prog_we   [3];
  logic [8:0]  prog_addr [3];
  logic [31:0] prog_data [3];
  logic [15:0] fetch_cnt [3];

  int lat_of [3];
  int exp_cnt [3];
  int total;
  int bad;

  // u0: LATENCY=1, base 0; u1: LATENCY=3, base 0; u2: LATENCY=4, base 0x400
  imem_fetch_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(512), .LATENCY(1), .BASE_ADDR(32'h0)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_instr(rsp_instr[0]), .rsp_err(rsp_err[0]), .prog_we(prog_we[0]),
    .prog_addr(prog_addr[0]), .prog_data(prog_data[0]), .fetch_cnt(fetch_cnt[0]));

  imem_fetch_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(512), .LATENCY(3), .BASE_ADDR(32'h0)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_instr(rsp_instr[1]), .rsp_err(rsp_err[1]), .prog_we(prog_we[1]),
    .prog_addr(prog_addr[1]), .prog_data(prog_data[1]), .fetch_cnt(fetch_cnt[1]));

  imem_fetch_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(512), .LATENCY(4), .BASE_ADDR(32'h400)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_instr(rsp_instr[2]), .rsp_err(rsp_err[2]), .prog_we(prog_we[2]),
    .prog_addr(prog_addr[2]), .prog_data(prog_data[2]), .fetch_cnt(fetch_cnt[2]));

  // ---------------- vector table ----------------
  typedef struct {
    int          k;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs [16];

  // ---------------- checker ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic prog_word(input int k, input logic [8:0] idx, input logic [31:0] data);
    @(negedge clk);
    prog_we[k]   = 1'b1;
    prog_addr[k] = idx;
    prog_data[k] = data;
    @(negedge clk);
    prog_we[k]   = 1'b0;
  endtask

  // Presents one request with rsp_ready high, checks accept, latency and
  // payload. Returns at the negedge where rsp_valid is seen; the response is
  // consumed on the following posedge.
  task automatic do_fetch(input int k, input logic [31:0] addr,
                          input logic [31:0] exp_instr, input logic exp_err);
    int t;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_addr[k]  = addr;
    rsp_ready[k] = 1'b1;
    chk("req_ready idle", 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    t = 0;
    do begin
      @(negedge clk);
      req_valid[k] = 1'b0;
      t++;
    end while (!rsp_valid[k] && t < 10);
    chk("latency", 32'(t), 32'(lat_of[k]));
    chk("rsp_instr", rsp_instr[k], exp_instr);
    chk("rsp_err", 32'(rsp_err[k]), 32'(exp_err));
    exp_cnt[k]++;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    total = 0;
    bad   = 0;
    lat_of = '{1, 3, 4};
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_addr[k] = '0; rsp_ready[k] = 1'b0;
      prog_we[k] = 1'b0; prog_addr[k] = '0; prog_data[k] = '0; exp_cnt[k] = 0;
    end

    vecs[0]  = '{1, 32'h0000_00A0, 32'h2008_0002, 1'b0};
    vecs[1]  = '{1, 32'h0000_00A4, 32'h2009_0002, 1'b0};
    vecs[2]  = '{1, 32'h0000_00A8, 32'h1109_0002, 1'b0};
    vecs[3]  = '{0, 32'h0000_00A0, 32'h2008_0002, 1'b0};
    vecs[4]  = '{0, 32'h0000_00A4, 32'h2009_0002, 1'b0};
    vecs[5]  = '{0, 32'h0000_00A8, 32'h1109_0002, 1'b0};
    vecs[6]  = '{0, 32'h0000_00A2, 32'h0000_0000, 1'b1};
    vecs[7]  = '{0, 32'h0000_0800, 32'h0000_0000, 1'b1};
    vecs[8]  = '{0, 32'h0000_07FC, 32'h1234_5678, 1'b0};
    vecs[9]  = '{0, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[10] = '{0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[11] = '{2, 32'h0000_03FC, 32'h0000_0000, 1'b1};
    vecs[12] = '{2, 32'h0000_0400, 32'hCAFE_F00D, 1'b0};
    vecs[13] = '{2, 32'h0000_0BFC, 32'h1234_5678, 1'b0};
    vecs[14] = '{2, 32'h0000_0C00, 32'h0000_0000, 1'b1};
    vecs[15] = '{2, 32'h0000_04A8, 32'h1109_0002, 1'b0};

    // reset for 2 cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset req_ready", 32'(req_ready[k]), 32'd0);
      chk("reset rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("reset fetch_cnt", 32'(fetch_cnt[k]), 32'd0);
      chk("reset rsp_instr", rsp_instr[k], 32'd0);
      chk("reset rsp_err", 32'(rsp_err[k]), 32'd0);
      rst_n[k] = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("post-reset req_ready", 32'(req_ready[k]), 32'd1);
    end

    // program load
    for (int k = 0; k < 3; k++) begin
      prog_word(k, 9'd40, 32'h2008_0002);
      prog_word(k, 9'd41, 32'h2009_0002);
      prog_word(k, 9'd42, 32'h1109_0002);
      prog_word(k, 9'd0, 32'hCAFE_F00D);
      prog_word(k, 9'd511, 32'h1234_5678);
      prog_word(k, 9'd10, 32'h0000_0000);
    end

    // table-driven fetches
    for (int i = 0; i < 16; i++) begin
      do_fetch(vecs[i].k, vecs[i].addr, vecs[i].instr, vecs[i].err);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("fetch_cnt table", 32'(fetch_cnt[k]), 32'(exp_cnt[k]));
    end

    // back-pressure: response held 5 cycles, second request waits
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0000_00A0;
    rsp_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_addr[0] = 32'h0000_00A4;
    for (int i = 0; i < 5; i++) begin
      chk("hold rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("hold rsp_instr", rsp_instr[0], 32'h2008_0002);
      chk("hold rsp_err", 32'(rsp_err[0]), 32'd0);
      chk("hold req_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("after take rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("after take req_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("second rsp_valid", 32'(rsp_valid[0]), 32'd1);
    chk("second rsp_instr", rsp_instr[0], 32'h2009_0002);
    exp_cnt[0] += 2;

    // write to the fetched word on the accept edge: old value returned
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0000_0028;
    prog_we[0]   = 1'b1;
    prog_addr[0] = 9'd10;
    prog_data[0] = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    prog_we[0]   = 1'b0;
    chk("collide rsp_valid", 32'(rsp_valid[0]), 32'd1);
    chk("collide rsp_instr", rsp_instr[0], 32'h0000_0000);
    exp_cnt[0]++;
    do_fetch(0, 32'h0000_0028, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    chk("fetch_cnt u0", 32'(fetch_cnt[0]), 32'(exp_cnt[0]));

    // reset during WAIT drops the request, memory persists
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_addr[2]  = 32'h0000_0400;
    rsp_ready[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    rst_n[2]     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset req_ready", 32'(req_ready[2]), 32'd0);
    chk("midreset rsp_valid", 32'(rsp_valid[2]), 32'd0);
    rst_n[2] = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid[2]) seen++;
    end
    chk("dropped rsp count", 32'(seen), 32'd0);
    chk("idle after reset", 32'(req_ready[2]), 32'd1);
    chk("fetch_cnt cleared", 32'(fetch_cnt[2]), 32'd0);
    exp_cnt[2] = 0;
    do_fetch(2, 32'h0000_04A4, 32'h2009_0002, 1'b0);
    @(negedge clk);
    chk("fetch_cnt u2", 32'(fetch_cnt[2]), 32'(exp_cnt[2]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
